instr_mem_responder: RTL and testbench

//  Instruction-memory responder on the fetch interface of the RISC-V core.

---
 rtl/instr_mem_responder.sv | 150 +++++++++++++++
 tb/tb_instr_mem_responder.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_responder.sv
// Instruction-memory responder: returns the 32-bit word at a byte fetch address, with a side loader port.
// Latency: rsp_valid rises LATENCY cycles after request accept; one request in flight at a time.
// Backpressure: req_ready is low while a fetch is outstanding; the response is held until rsp_ready.
module instr_mem_responder #(
  parameter int ADDR_W  = 8,
  parameter int LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic [63:0]       req_addr,
  output logic              req_ready,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_instr,
  output logic [1:0]        rsp_err,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [31:0]       ld_data
);

  localparam int          DEPTH = 1 << ADDR_W;
  localparam int          CNT_W = 3;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  localparam logic [1:0] ERR_OK    = 2'b00;
  localparam logic [1:0] ERR_ALIGN = 2'b01;
  localparam logic [1:0] ERR_RANGE = 2'b10;

  // Parameter sanity: the counter is sized for LATENCY up to 4 and the
  // range check needs at least one address bit above the word index.
  if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
    $error("instr_mem_responder: LATENCY must be in 1..4");
  end
  if (ADDR_W < 1 || ADDR_W > 61) begin : g_bad_addr_w
    $error("instr_mem_responder: ADDR_W must be in 1..61");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_nxt;

  logic [31:0]        mem [DEPTH];

  logic               accept;
  logic               misaligned;
  logic               out_of_range;
  logic [ADDR_W-1:0]  idx;
  logic [31:0]        cap_instr;
  logic [1:0]         cap_err;

  logic [31:0]        instr_q;
  logic [1:0]         err_q;

  // A request is only taken in IDLE; req_valid in any other state is ignored.
  assign accept       = (state == IDLE) && req_valid;
  assign misaligned   = |req_addr[1:0];
  // Any set bit above the word index means the word address is past the
  // array; no wrap-around onto low words.
  assign out_of_range = |req_addr[63:ADDR_W+2];
  assign idx          = req_addr[ADDR_W+1:2];

  // Capture value for an accepted fetch: alignment fault beats range fault.
  always_comb begin
    cap_instr = NOP;
    cap_err   = ERR_OK;
    if (misaligned) begin
      cap_instr = NOP;
      cap_err   = ERR_ALIGN;
    end else if (out_of_range) begin
      cap_instr = NOP;
      cap_err   = ERR_RANGE;
    end else begin
      // Array read sees the pre-edge contents, so a same-cycle load to this
      // word returns the old value.
      cap_instr = mem[idx];
      cap_err   = ERR_OK;
    end
  end

  // Next-state and wait-counter logic.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (LATENCY == 1) begin
            state_nxt = RESP;
          end else begin
            state_nxt = WAIT;
            cnt_nxt   = CNT_W'(LATENCY - 1);
          end
        end
      end
      WAIT: begin
        cnt_nxt = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          state_nxt = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // State, counter and response register; reset abandons any outstanding fetch.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      instr_q <= '0;
      err_q   <= ERR_OK;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        instr_q <= cap_instr;
        err_q   <= cap_err;
      end
    end
  end

  // Loader write port: active in any FSM state, suppressed during reset.
  always_ff @(posedge clk) begin
    if (reset && ld_we) begin
      mem[ld_addr] <= ld_data;
    end
  end

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign rsp_instr = instr_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_instr_mem_responder.sv
// Bench for instr_mem_responder: two instances (LATENCY 1 and 3) checked against an array model.
module tb_instr_mem_responder;

  localparam int          AW  = 8;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset     [2];
  logic          req_valid [2];
  logic [63:0]   req_addr  [2];
  logic          req_ready [2];
  logic          rsp_valid [2];
  logic          rsp_ready [2];
  logic [31:0]   rsp_instr [2];
  logic [1:0]    rsp_err   [2];
  logic          ld_we     [2];
  logic [AW-1:0] ld_addr   [2];
  logic [31:0]   ld_data   [2];

  logic [31:0]   ref_mem [2][256];
  int            n_chk  = 0;
  int            n_fail = 0;

  instr_mem_responder #(.ADDR_W(AW), .LATENCY(1)) u_lat1 (
    .clk(clk), .reset(reset[0]),
    .req_valid(req_valid[0]), .req_addr(req_addr[0]), .req_ready(req_ready[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_instr(rsp_instr[0]), .rsp_err(rsp_err[0]),
    .ld_we(ld_we[0]), .ld_addr(ld_addr[0]), .ld_data(ld_data[0])
  );

  instr_mem_responder #(.ADDR_W(AW), .LATENCY(3)) u_lat3 (
    .clk(clk), .reset(reset[1]),
    .req_valid(req_valid[1]), .req_addr(req_addr[1]), .req_ready(req_ready[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_instr(rsp_instr[1]), .rsp_err(rsp_err[1]),
    .ld_we(ld_we[1]), .ld_addr(ld_addr[1]), .ld_data(ld_data[1])
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int lat_of(input int s);
    return (s == 0) ? 1 : 3;
  endfunction

  // Expected {err, instr} for a fetch address, from the fault rules and the word array.
  function automatic logic [33:0] model(input int s, input logic [63:0] a);
    if (a[1:0] != 2'b00)     return {2'b01, NOP};
    if (a[63:2] >= 62'd256)  return {2'b10, NOP};
    return {2'b00, ref_mem[s][a[9:2]]};
  endfunction

  // All tasks start and end just after a rising edge.
  task automatic ld(input int s, input logic [7:0] a, input logic [31:0] d);
    ld_we[s] = 1'b1; ld_addr[s] = a; ld_data[s] = d;
    @(posedge clk); #1;
    ld_we[s] = 1'b0;
    ref_mem[s][a] = d;
  endtask

  task automatic fetch(input int s, input logic [63:0] a, input int hold,
                       input bit acc_ld, input logic [7:0] acc_idx, input logic [31:0] acc_dat,
                       input bit busy_ld, input string tag);
    logic [33:0] exp;
    logic [31:0] bd;
    int          lat;
    lat = lat_of(s);
    bd  = $urandom;
    req_valid[s] = 1'b1;
    req_addr[s]  = a;
    if (acc_ld) begin
      ld_we[s] = 1'b1; ld_addr[s] = acc_idx; ld_data[s] = acc_dat;
    end
    @(negedge clk);
    check({tag, "_rdy_idle"}, 64'(req_ready[s]), 64'(1));
    exp = model(s, a);
    @(posedge clk); #1;
    if (acc_ld) begin
      ld_we[s] = 1'b0;
      ref_mem[s][acc_idx] = acc_dat;
    end
    // Keep requesting a different address while busy; it must be ignored.
    req_addr[s] = {$urandom, $urandom};
    for (int k = 1; k <= lat + hold; k++) begin
      if (busy_ld && k == 1) begin
        ld_we[s] = 1'b1; ld_addr[s] = a[9:2]; ld_data[s] = bd;
      end
      rsp_ready[s] = (k == lat + hold);
      @(negedge clk);
      check({tag, "_vld"}, 64'(rsp_valid[s]), 64'(k >= lat));
      check({tag, "_rdy_busy"}, 64'(req_ready[s]), 64'(0));
      if (k >= lat) begin
        check({tag, "_instr"}, 64'(rsp_instr[s]), 64'(exp[31:0]));
        check({tag, "_err"}, 64'(rsp_err[s]), 64'(exp[33:32]));
      end
      @(posedge clk); #1;
      if (busy_ld && k == 1) begin
        ld_we[s] = 1'b0;
        ref_mem[s][a[9:2]] = bd;
      end
    end
    req_valid[s] = 1'b0;
    rsp_ready[s] = 1'b0;
    @(negedge clk);
    check({tag, "_vld_done"}, 64'(rsp_valid[s]), 64'(0));
    check({tag, "_rdy_done"}, 64'(req_ready[s]), 64'(1));
    @(posedge clk); #1;
  endtask

  task automatic reset_outputs(input int s, input string tag);
    check({tag, "_rdy"}, 64'(req_ready[s]), 64'(1));
    check({tag, "_vld"}, 64'(rsp_valid[s]), 64'(0));
    check({tag, "_instr"}, 64'(rsp_instr[s]), 64'(0));
    check({tag, "_err"}, 64'(rsp_err[s]), 64'(0));
  endtask

  initial begin
    logic [63:0] a;
    int          r;
    for (int s = 0; s < 2; s++) begin
      reset[s] = 1'b0; req_valid[s] = 1'b0; req_addr[s] = '0; rsp_ready[s] = 1'b0;
      ld_we[s] = 1'b0; ld_addr[s] = '0; ld_data[s] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    reset[0] = 1'b1; reset[1] = 1'b1;
    @(negedge clk);
    reset_outputs(0, "rst0");
    reset_outputs(1, "rst1");
    @(posedge clk); #1;

    // Preload every word so all in-range fetches have defined data.
    for (int i = 0; i < 256; i++) begin
      for (int s = 0; s < 2; s++) ld(s, 8'(i), (i == 4) ? 32'h0 : $urandom);
    end

    // Program words, LATENCY 1.
    ld(0, 8'd0, 32'h0050_0093);
    ld(0, 8'd1, 32'h00A0_0113);
    fetch(0, 64'h0, 0, 0, 8'd0, 32'h0, 0, "t1_a");
    fetch(0, 64'h4, 0, 0, 8'd0, 32'h0, 0, "t1_b");

    // LATENCY 3.
    ld(1, 8'd2, 32'hDEAD_BEEF);
    fetch(1, 64'h8, 0, 0, 8'd0, 32'h0, 0, "t2");

    // Fault cases on both instances.
    for (int s = 0; s < 2; s++) begin
      fetch(s, 64'h6, 0, 0, 8'd0, 32'h0, 0, "t3_misal");
      fetch(s, 64'h400, 0, 0, 8'd0, 32'h0, 0, "t3_range");
      fetch(s, 64'h401, 0, 0, 8'd0, 32'h0, 0, "t3_prio");
      fetch(s, 64'hFFFF_FFFF_FFFF_FFFC, 0, 0, 8'd0, 32'h0, 0, "t3_top");
      fetch(s, 64'h3FC, 1, 0, 8'd0, 32'h0, 0, "t3_last");
    end

    // Stalled response with a load to the same word while held.
    fetch(1, 64'hC, 5, 0, 8'd0, 32'h0, 1, "t4_l3");
    fetch(0, 64'hC, 5, 0, 8'd0, 32'h0, 1, "t4_l1");
    fetch(1, 64'hC, 0, 0, 8'd0, 32'h0, 0, "t4_refetch");

    // Same-cycle accept and load: old word, then new word.
    fetch(0, 64'h10, 0, 1, 8'd4, 32'h1234_5678, 0, "t5_old");
    fetch(0, 64'h10, 0, 0, 8'd0, 32'h0, 0, "t5_new");

    // Reset while waiting; a load in the reset cycle is dropped.
    req_valid[1] = 1'b1; req_addr[1] = 64'h14;
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    @(negedge clk);
    check("t6_wait_vld", 64'(rsp_valid[1]), 64'(0));
    reset[1] = 1'b0;
    ld_we[1] = 1'b1; ld_addr[1] = 8'd5; ld_data[1] = ~ref_mem[1][5];
    @(posedge clk); #1;
    reset[1] = 1'b1;
    ld_we[1] = 1'b0;
    @(negedge clk);
    reset_outputs(1, "t6_after");
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("t6_quiet", 64'(rsp_valid[1]), 64'(0));
    end
    @(posedge clk); #1;
    fetch(1, 64'h14, 0, 0, 8'd0, 32'h0, 0, "t6_new");
    fetch(1, 64'h8, 0, 0, 8'd0, 32'h0, 0, "t6_mem");

    // Randomized traffic.
    for (int s = 0; s < 2; s++) begin
      for (int n = 0; n < 40; n++) begin
        r = $urandom_range(0, 9);
        a = 64'($urandom_range(0, 255)) << 2;
        if (r == 6 || r == 7) a[1:0] = 2'($urandom_range(1, 3));
        if (r >= 8) begin
          a = {$urandom, $urandom};
          a[10 + $urandom_range(0, 53)] = 1'b1;
        end
        fetch(s, a, $urandom_range(0, 3), ($urandom_range(0, 2) == 0),
              ($urandom_range(0, 1) == 0) ? a[9:2] : 8'($urandom_range(0, 255)),
              $urandom, ($urandom_range(0, 3) == 0), "rnd");
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
